expr_eval: RTL and testbench

- Downstream companion of the expression recogniser, evaluating a streamed ASCII expression.
- Consumes the same one-character-per-clock stream: single decimal digits separated by '+' or '*'.
- Keeps a running numeric value of the prefix received so far, with '*' binding tighter than '+'.
- Flags when the prefix is a complete, well-formed expression.
- Sits beside/after the recogniser on the same `in` bus and feeds result display/compare logic.

---
 rtl/expr_pkg.sv | 19 +
 rtl/expr_char_class.sv | 21 ++
 rtl/expr_eval.sv | 112 +++++++++++
 tb/tb_expr_eval.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the streamed-expression evaluator and its
// character classifier: FSM states, ASCII constants and default width.
package expr_pkg;

   localparam int EXPR_W = 16;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;

   // S_DIGIT: expecting a digit; S_OP: expecting an operator; S_ERR: absorbing
   typedef enum logic [1:0] {
      S_DIGIT = 2'd0,
      S_OP    = 2'd1,
      S_ERR   = 2'd2
   } expr_state_e;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier for the expression stream. Kept separate so
// the recogniser and the evaluator can share identical decoding.
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0] in,
   output logic       is_digit,
   output logic       is_plus,
   output logic       is_star,
   output logic [3:0] digit
);

   // Decode the character; the low nibble of '0'..'9' is the digit itself
   always_comb begin
      is_digit = (in >= CH_0) && (in <= CH_9);
      is_plus  = (in == CH_PLUS);
      is_star  = (in == CH_STAR);
      digit    = is_digit ? in[3:0] : 4'd0;
   end

endmodule

// File: rtl/expr_eval.sv
// Evaluates a streamed "digit op digit op ..." expression one character per
// clock, with '*' binding tighter than '+'. The running value is kept as a
// completed-terms sum plus the current product term, so the displayed value
// of any prefix is simply sum+prod.
module expr_eval
   import expr_pkg::*;
#(
   parameter int W = EXPR_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   output logic [W-1:0] value,
   output logic         valid,
   output logic         err,
   output logic         ovf
);

   expr_state_e  st_q, st_d;
   logic [W-1:0] sum_q, sum_d;
   logic [W-1:0] prod_q, prod_d;
   logic         mul_q, mul_d;
   logic         ovf_q, ovf_d;

   logic         isDigit;
   logic         isPlus;
   logic         isStar;
   logic [3:0]   digitVal;
   logic [W+3:0] mulFull;
   logic [W:0]   addFull;

   expr_char_class u_class (
      .in       (in),
      .is_digit (isDigit),
      .is_plus  (isPlus),
      .is_star  (isStar),
      .digit    (digitVal)
   );

   // Wide product and sum so the bits lost to the W-bit modulo are visible
   always_comb begin
      mulFull = (W+4)'(prod_q) * (W+4)'(digitVal);
      addFull = {1'b0, sum_q} + {1'b0, prod_q};
   end

   // Next-state and datapath update; an error state freezes all values
   always_comb begin
      st_d   = st_q;
      sum_d  = sum_q;
      prod_d = prod_q;
      mul_d  = mul_q;
      ovf_d  = ovf_q;
      unique case (st_q)
         S_DIGIT: begin
            if (isDigit) begin
               if (mul_q) begin
                  prod_d = mulFull[W-1:0];
                  if (|mulFull[W+3:W]) ovf_d = 1'b1;
               end else begin
                  prod_d = W'(digitVal);
               end
               st_d = S_OP;
            end else begin
               st_d = S_ERR;
            end
         end
         S_OP: begin
            if (isPlus) begin
               sum_d  = addFull[W-1:0];
               prod_d = '0;
               mul_d  = 1'b0;
               if (addFull[W]) ovf_d = 1'b1;
               st_d   = S_DIGIT;
            end else if (isStar) begin
               mul_d = 1'b1;
               st_d  = S_DIGIT;
            end else begin
               st_d = S_ERR;
            end
         end
         default: begin
            st_d = S_ERR;
         end
      endcase
   end

   // State register; clr wins over the character sampled on the same edge
   always_ff @(posedge clk) begin
      if (clr) begin
         st_q   <= S_DIGIT;
         sum_q  <= '0;
         prod_q <= '0;
         mul_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         sum_q  <= sum_d;
         prod_q <= prod_d;
         mul_q  <= mul_d;
         ovf_q  <= ovf_d;
      end
   end

   // Outputs depend only on registered state, never directly on the input
   always_comb begin
      value = addFull[W-1:0];
      valid = (st_q == S_OP);
      err   = (st_q == S_ERR);
      ovf   = ovf_q | addFull[W];
   end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a table of per-edge characters with
// hand-computed expected outputs on a 16-bit instance, plus hand-written
// overflow sequences on a 4-bit instance sharing the same input bus.
module tb_expr_eval;

   logic        clk;
   logic        clr;
   logic [7:0]  inCh;

   logic [15:0] value16;
   logic        valid16, err16, ovf16;
   logic [3:0]  value4;
   logic        valid4, err4, ovf4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        doClr;
      logic [7:0]  ch;
      logic [15:0] expValue;
      logic        expValid;
      logic        expErr;
      logic        expOvf;
   } step_t;

   step_t steps[$];

   expr_eval #(.W(16)) dut16 (
      .clk   (clk),
      .clr   (clr),
      .in    (inCh),
      .value (value16),
      .valid (valid16),
      .err   (err16),
      .ovf   (ovf16)
   );

   expr_eval #(.W(4)) dut4 (
      .clk   (clk),
      .clr   (clr),
      .in    (inCh),
      .value (value4),
      .valid (valid4),
      .err   (err4),
      .ovf   (ovf4)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one character (or clr) for exactly one rising edge, then settle
   task automatic applyStimulus(input logic doClr, input logic [7:0] ch);
      @(negedge clk);
      clr  = doClr;
      inCh = ch;
      @(posedge clk);
      #1;
   endtask

   // Compare one instance's outputs against expectations
   task automatic checkOutput(input string name, input bit narrow,
                              input logic [15:0] expValue, input logic expValid,
                              input logic expErr, input logic expOvf);
      logic [15:0] actValue;
      logic        actValid, actErr, actOvf;
      if (narrow) begin
         actValue = {12'd0, value4};
         actValid = valid4;
         actErr   = err4;
         actOvf   = ovf4;
      end else begin
         actValue = value16;
         actValid = valid16;
         actErr   = err16;
         actOvf   = ovf16;
      end
      checks++;
      if (actValue !== expValue || actValid !== expValid ||
          actErr !== expErr || actOvf !== expOvf) begin
         errors++;
         $display("[TB] FAIL %s: got value=%0d valid=%b err=%b ovf=%b, want value=%0d valid=%b err=%b ovf=%b",
                  name, actValue, actValid, actErr, actOvf,
                  expValue, expValid, expErr, expOvf);
      end
   endtask

   function automatic step_t mk(input logic c, input logic [7:0] ch,
                                input int v, input logic vl,
                                input logic e, input logic o);
      step_t s;
      s.doClr    = c;
      s.ch       = ch;
      s.expValue = 16'(v);
      s.expValid = vl;
      s.expErr   = e;
      s.expOvf   = o;
      return s;
   endfunction

   initial begin
      clr  = 1'b1;
      inCh = 8'h00;

      // 1+2+3*4 = 15, valid toggling on each edge
      steps.push_back(mk(1, "9",  0, 0, 0, 0));
      steps.push_back(mk(0, "1",  1, 1, 0, 0));
      steps.push_back(mk(0, "+",  1, 0, 0, 0));
      steps.push_back(mk(0, "2",  3, 1, 0, 0));
      steps.push_back(mk(0, "+",  3, 0, 0, 0));
      steps.push_back(mk(0, "3",  6, 1, 0, 0));
      steps.push_back(mk(0, "*",  6, 0, 0, 0));
      steps.push_back(mk(0, "4", 15, 1, 0, 0));
      // 2*3*4+5 = 29
      steps.push_back(mk(1, "1",  0, 0, 0, 0));
      steps.push_back(mk(0, "2",  2, 1, 0, 0));
      steps.push_back(mk(0, "*",  2, 0, 0, 0));
      steps.push_back(mk(0, "3",  6, 1, 0, 0));
      steps.push_back(mk(0, "*",  6, 0, 0, 0));
      steps.push_back(mk(0, "4", 24, 1, 0, 0));
      steps.push_back(mk(0, "+", 24, 0, 0, 0));
      steps.push_back(mk(0, "5", 29, 1, 0, 0));
      // 1++ errors and sticks; clr recovers
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "1",  1, 1, 0, 0));
      steps.push_back(mk(0, "+",  1, 0, 0, 0));
      steps.push_back(mk(0, "+",  1, 0, 1, 0));
      steps.push_back(mk(0, "5",  1, 0, 1, 0));
      steps.push_back(mk(1, "5",  0, 0, 0, 0));
      // illegal first character
      steps.push_back(mk(0, "x",  0, 0, 1, 0));
      // leading operator
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "+",  0, 0, 1, 0));
      // two digits in a row
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "3",  3, 1, 0, 0));
      steps.push_back(mk(0, "4",  3, 0, 1, 0));
      // illegal char where an operator is expected
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "8",  8, 1, 0, 0));
      steps.push_back(mk(0, "-",  8, 0, 1, 0));
      // clr on the same edge as '7' mid-expression, then a fresh '7'
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "3",  3, 1, 0, 0));
      steps.push_back(mk(0, "*",  3, 0, 0, 0));
      steps.push_back(mk(1, "7",  0, 0, 0, 0));
      steps.push_back(mk(0, "7",  7, 1, 0, 0));
      // single zero
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "0",  0, 1, 0, 0));
      // 5*0+6 = 6
      steps.push_back(mk(1, "0",  0, 0, 0, 0));
      steps.push_back(mk(0, "5",  5, 1, 0, 0));
      steps.push_back(mk(0, "*",  5, 0, 0, 0));
      steps.push_back(mk(0, "0",  0, 1, 0, 0));
      steps.push_back(mk(0, "+",  0, 0, 0, 0));
      steps.push_back(mk(0, "6",  6, 1, 0, 0));
      // 9^6 overflows 16 bits: 531441 mod 65536 = 7153
      steps.push_back(mk(1, "0",     0, 0, 0, 0));
      steps.push_back(mk(0, "9",     9, 1, 0, 0));
      steps.push_back(mk(0, "*",     9, 0, 0, 0));
      steps.push_back(mk(0, "9",    81, 1, 0, 0));
      steps.push_back(mk(0, "*",    81, 0, 0, 0));
      steps.push_back(mk(0, "9",   729, 1, 0, 0));
      steps.push_back(mk(0, "*",   729, 0, 0, 0));
      steps.push_back(mk(0, "9",  6561, 1, 0, 0));
      steps.push_back(mk(0, "*",  6561, 0, 0, 0));
      steps.push_back(mk(0, "9", 59049, 1, 0, 0));
      steps.push_back(mk(0, "*", 59049, 0, 0, 0));
      steps.push_back(mk(0, "9",  7153, 1, 0, 1));
      steps.push_back(mk(0, "+",  7153, 0, 0, 1));

      foreach (steps[i]) begin
         applyStimulus(steps[i].doClr, steps[i].ch);
         checkOutput($sformatf("w16 step%0d '%c'", i, steps[i].ch), 1'b0,
                     steps[i].expValue, steps[i].expValid,
                     steps[i].expErr, steps[i].expOvf);
      end

      // W=4: 9*9 = 81 mod 16 = 1 with sticky product overflow
      applyStimulus(1'b1, "0"); checkOutput("w4 clr",       1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, "9"); checkOutput("w4 mul 9",     1'b1, 9, 1, 0, 0);
      applyStimulus(1'b0, "*"); checkOutput("w4 mul *",     1'b1, 9, 0, 0, 0);
      applyStimulus(1'b0, "9"); checkOutput("w4 mul 9*9",   1'b1, 1, 1, 0, 1);
      applyStimulus(1'b0, "+"); checkOutput("w4 mul +",     1'b1, 1, 0, 0, 1);
      applyStimulus(1'b0, "9"); checkOutput("w4 mul +9",    1'b1, 10, 1, 0, 1);

      // W=4: 9+9 = 18 mod 16 = 2, carry shown live then made sticky by '+'
      applyStimulus(1'b1, "0"); checkOutput("w4 clr2",      1'b1, 0, 0, 0, 0);
      applyStimulus(1'b0, "9"); checkOutput("w4 add 9",     1'b1, 9, 1, 0, 0);
      applyStimulus(1'b0, "+"); checkOutput("w4 add +",     1'b1, 9, 0, 0, 0);
      applyStimulus(1'b0, "9"); checkOutput("w4 add 9+9",   1'b1, 2, 1, 0, 1);
      applyStimulus(1'b0, "+"); checkOutput("w4 add sticky",1'b1, 2, 0, 0, 1);
      applyStimulus(1'b0, "1"); checkOutput("w4 add +1",    1'b1, 3, 1, 0, 1);
      applyStimulus(1'b1, "0"); checkOutput("w4 clr3",      1'b1, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
